// File: rtl/vic_wb_buffer_pkg.sv
// Shared definitions for the victim-cache writeback buffer: line format,
// bus command encodings, buffer sizing and the writeback FSM states.
package vic_wb_buffer_pkg;

  localparam int NUM_SET_BITS = 5;
  localparam int NUM_TAG_BITS = 56;

  localparam int WB_SIZE     = 4;
  localparam int NUM_WB_BITS = $clog2(WB_SIZE);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef enum logic [1:0] {
    WB_IDLE = 2'h0,
    WB_REQ  = 2'h1,
    WB_WAIT = 2'h2
  } WB_STATE_T;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] idx;
    logic [63:0]             data;
  } VIC_CACHE_T;

  localparam VIC_CACHE_T EMPTY_VIC_CACHE = '0;

  // Byte address of a line: tag and set index above an 8-byte offset.
  function automatic logic [63:0] line_addr(input VIC_CACHE_T line);
    return {line.tag, line.idx, 3'b000};
  endfunction

endpackage

// File: rtl/vic_wb_buffer_cam.sv
// Content-addressable match array: every lookup key is compared against
// every stored key; a hit needs the lookup enabled and the entry valid.
module vic_wb_buffer_cam #(
  parameter int LENGTH   = 4,
  parameter int NUM_TAGS = 2,
  parameter int WIDTH    = 8
) (
  input  logic [LENGTH-1:0]                valid,
  input  logic [LENGTH-1:0][WIDTH-1:0]     keys,
  input  logic [NUM_TAGS-1:0]              enable,
  input  logic [NUM_TAGS-1:0][WIDTH-1:0]   tags,
  output logic [NUM_TAGS-1:0][LENGTH-1:0]  hits
);

  // Full cross-product of lookup keys against stored keys.
  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      for (int e = 0; e < LENGTH; e++) begin
        hits[t][e] = enable[t] && valid[e] && (keys[e] == tags[t]);
      end
    end
  end

endmodule

// File: rtl/vic_wb_buffer.sv
// Writeback buffer between the victim cache and memory. Dirty evictions are
// queued in a circular FIFO and stored to memory one at a time; pending
// lines can be forwarded to loads through a CAM lookup.
module vic_wb_buffer
  import vic_wb_buffer_pkg::VIC_CACHE_T, vic_wb_buffer_pkg::EMPTY_VIC_CACHE,
         vic_wb_buffer_pkg::WB_STATE_T, vic_wb_buffer_pkg::WB_IDLE,
         vic_wb_buffer_pkg::WB_REQ, vic_wb_buffer_pkg::WB_WAIT,
         vic_wb_buffer_pkg::BUS_NONE, vic_wb_buffer_pkg::BUS_STORE,
         vic_wb_buffer_pkg::NUM_SET_BITS, vic_wb_buffer_pkg::NUM_TAG_BITS,
         vic_wb_buffer_pkg::line_addr;
#(
  parameter int WR_PORTS = 3,
  parameter int RD_PORTS = 2,
  parameter int WB_SIZE  = vic_wb_buffer_pkg::WB_SIZE
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  VIC_CACHE_T [WR_PORTS-1:0]               evicted_vic,
  input  logic [WR_PORTS-1:0]                     evicted_valid,
  input  logic [RD_PORTS-1:0]                     rd_en,
  input  logic [RD_PORTS-1:0][NUM_SET_BITS-1:0]   rd_idx,
  input  logic [RD_PORTS-1:0][NUM_TAG_BITS-1:0]   rd_tag,
  output logic [RD_PORTS-1:0]                     rd_hit,
  output logic [RD_PORTS-1:0][63:0]               rd_data,
  input  logic                                    mem_grant,
  output logic                                    wb_req,
  output logic [1:0]                              proc2mem_command,
  output logic [63:0]                             proc2mem_addr,
  output logic [63:0]                             proc2mem_data,
  input  logic [3:0]                              mem2proc_response,
  output logic                                    wb_stall,
  output logic                                    wb_overflow
);

  localparam int IDX_W = $clog2(WB_SIZE);
  localparam int PTR_W = IDX_W + 1;
  localparam int KEY_W = NUM_TAG_BITS + NUM_SET_BITS;

  VIC_CACHE_T                          entries [WB_SIZE];
  logic [PTR_W-1:0]                    head, tail, count, count_next, enq_cnt;
  logic [IDX_W-1:0]                    head_idx;
  WB_STATE_T                           state, state_next;
  logic [WR_PORTS-1:0]                 enq_ok;
  logic [WR_PORTS-1:0][IDX_W-1:0]      enq_slot;
  logic                                dropped, pop, issue;
  int                                  free_slots;

  logic [WB_SIZE-1:0]                  cam_valid;
  logic [WB_SIZE-1:0][KEY_W-1:0]       cam_keys;
  logic [RD_PORTS-1:0][KEY_W-1:0]      rd_keys;
  logic [RD_PORTS-1:0][WB_SIZE-1:0]    cam_hits;

  assign head_idx   = head[IDX_W-1:0];
  // Free space comes from the registered count only, so a pop this cycle
  // does not make room for this cycle's evictions.
  assign free_slots = WB_SIZE - int'(count);
  assign wb_stall   = (free_slots < WR_PORTS);
  assign pop        = (state == WB_WAIT) && (mem2proc_response != 4'h0);
  assign count_next = count + enq_cnt - PTR_W'(pop);

  // Pack qualifying ports into consecutive free slots, lowest port first.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise paths
    // that skip an assignment would infer a latch.
    enq_cnt  = '0;
    dropped  = 1'b0;
    enq_ok   = '0;
    enq_slot = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (evicted_valid[p] && evicted_vic[p].valid && evicted_vic[p].dirty) begin
        if (int'(enq_cnt) < free_slots) begin
          enq_ok[p]   = 1'b1;
          enq_slot[p] = tail[IDX_W-1:0] + enq_cnt[IDX_W-1:0];
          enq_cnt     = enq_cnt + PTR_W'(1);
        end else begin
          dropped = 1'b1;
        end
      end
    end
  end

  // Line storage: write accepted evictions, invalidate the head on pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is only WB_SIZE lines and lookup trusts the valid
      // bits, so the whole array is reset rather than just the pointers.
      for (int i = 0; i < WB_SIZE; i++) entries[i] <= EMPTY_VIC_CACHE;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (pop) entries[head_idx].valid <= 1'b0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if (enq_ok[p]) entries[enq_slot[p]] <= evicted_vic[p];
      end
    end
  end

  // FIFO pointers, occupancy, FSM state and the overflow pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= WB_IDLE;
      wb_overflow <= 1'b0;
    end else begin
      head        <= head + PTR_W'(pop);
      tail        <= tail + enq_cnt;
      count       <= count_next;
      state       <= state_next;
      wb_overflow <= dropped;
    end
  end

  // Writeback sequencing: request the bus, store once granted, then either
  // retire the head on a response or retry the same line.
  always_comb begin
    state_next = state;
    wb_req     = 1'b0;
    issue      = 1'b0;
    case (state)
      WB_IDLE: if (count != '0) state_next = WB_REQ;
      WB_REQ: begin
        wb_req = 1'b1;
        if (mem_grant) begin
          issue      = 1'b1;
          state_next = WB_WAIT;
        end
      end
      WB_WAIT: state_next = pop ? WB_IDLE : WB_REQ;
      default: state_next = WB_IDLE;
    endcase
  end

  assign proc2mem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = issue ? line_addr(entries[head_idx]) : '0;
  assign proc2mem_data    = issue ? entries[head_idx].data : '0;

  // Build CAM keys from stored lines and from the lookup ports.
  always_comb begin
    for (int i = 0; i < WB_SIZE; i++) begin
      cam_valid[i] = entries[i].valid & entries[i].dirty;
      cam_keys[i]  = {entries[i].tag, entries[i].idx};
    end
    for (int r = 0; r < RD_PORTS; r++) rd_keys[r] = {rd_tag[r], rd_idx[r]};
  end

  vic_wb_buffer_cam #(
    .LENGTH   (WB_SIZE),
    .NUM_TAGS (RD_PORTS),
    .WIDTH    (KEY_W)
  ) u_cam (
    .valid  (cam_valid),
    .keys   (cam_keys),
    .enable (rd_en),
    .tags   (rd_keys),
    .hits   (cam_hits)
  );

  // Walk slots oldest to youngest so the youngest matching line wins.
  always_comb begin
    logic [IDX_W-1:0] slot;
    slot    = '0;
    rd_hit  = '0;
    rd_data = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      for (int k = 0; k < WB_SIZE; k++) begin
        slot = head_idx + IDX_W'(k);
        if (cam_hits[r][slot]) begin
          rd_hit[r]  = 1'b1;
          rd_data[r] = entries[slot].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Directed bench for the victim-cache writeback buffer.
module tb_vic_wb_buffer;
  import vic_wb_buffer_pkg::*;

  localparam int WRP = 4;
  localparam int RDP = 2;

  logic                                clock = 1'b0;
  logic                                reset;
  VIC_CACHE_T [WRP-1:0]                evicted_vic;
  logic [WRP-1:0]                      evicted_valid;
  logic [RDP-1:0]                      rd_en;
  logic [RDP-1:0][NUM_SET_BITS-1:0]    rd_idx;
  logic [RDP-1:0][NUM_TAG_BITS-1:0]    rd_tag;
  logic [RDP-1:0]                      rd_hit;
  logic [RDP-1:0][63:0]                rd_data;
  logic                                mem_grant;
  logic                                wb_req;
  logic [1:0]                          proc2mem_command;
  logic [63:0]                         proc2mem_addr;
  logic [63:0]                         proc2mem_data;
  logic [3:0]                          mem2proc_response;
  logic                                wb_stall;
  logic                                wb_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  vic_wb_buffer #(
    .WR_PORTS (WRP),
    .RD_PORTS (RDP),
    .WB_SIZE  (WB_SIZE)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .evicted_vic       (evicted_vic),
    .evicted_valid     (evicted_valid),
    .rd_en             (rd_en),
    .rd_idx            (rd_idx),
    .rd_tag            (rd_tag),
    .rd_hit            (rd_hit),
    .rd_data           (rd_data),
    .mem_grant         (mem_grant),
    .wb_req            (wb_req),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .wb_stall          (wb_stall),
    .wb_overflow       (wb_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic VIC_CACHE_T mk(input logic dirty, input logic [NUM_SET_BITS-1:0] idx,
                                    input logic [NUM_TAG_BITS-1:0] tag, input logic [63:0] data);
    VIC_CACHE_T l;
    l.valid = 1'b1;
    l.dirty = dirty;
    l.idx   = idx;
    l.tag   = tag;
    l.data  = data;
    return l;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    evicted_vic       = '0;
    evicted_valid     = '0;
    rd_en             = '0;
    rd_idx            = '0;
    rd_tag            = '0;
    mem_grant         = 1'b0;
    mem2proc_response = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic lookup(input int port, input logic [NUM_SET_BITS-1:0] idx,
                        input logic [NUM_TAG_BITS-1:0] tag);
    rd_en[port]  = 1'b1;
    rd_idx[port] = idx;
    rd_tag[port] = tag;
  endtask

  task automatic wait_store(input string tag);
    int n;
    n = 0;
    #1;
    while (proc2mem_command != BUS_STORE && n < 20) begin
      step();
      #1;
      n++;
    end
    check({tag, "_store"}, 64'(proc2mem_command), 64'(BUS_STORE));
  endtask

  task automatic serve(input string tag, input logic [63:0] ea, input logic [63:0] ed,
                       input logic [3:0] resp);
    wait_store(tag);
    check({tag, "_addr"}, proc2mem_addr, ea);
    check({tag, "_data"}, proc2mem_data, ed);
    step();
    mem2proc_response = resp;
    #1;
    check({tag, "_wait_cmd"}, 64'(proc2mem_command), 64'(BUS_NONE));
    step();
    mem2proc_response = 4'h0;
  endtask

  task automatic no_store_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      step();
      #1;
      if (proc2mem_command == BUS_STORE) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    // Reset values while reset is held low
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    lookup(0, 5'd5, 56'h12);
    #1;
    check("rst_wb_req", 64'(wb_req), 64'd0);
    check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("rst_addr", proc2mem_addr, 64'd0);
    check("rst_data", proc2mem_data, 64'd0);
    check("rst_rd_hit", 64'(rd_hit), 64'd0);
    check("rst_stall", 64'(wb_stall), 64'd0);
    check("rst_overflow", 64'(wb_overflow), 64'd0);
    check("rst_count", 64'(dut.count), 64'd0);
    do_reset();

    // Single dirty eviction: visible at N+1, store at N+2, empty at N+4
    evicted_vic[0]   = mk(1'b1, 5'd5, 56'h12, 64'hAA);
    evicted_valid    = 4'b0001;
    mem_grant        = 1'b1;
    #1;
    check("a_n_wb_req", 64'(wb_req), 64'd0);
    step();
    evicted_valid = '0;
    lookup(0, 5'd5, 56'h12);
    #1;
    check("a_n1_count", 64'(dut.count), 64'd1);
    check("a_n1_hit", 64'(rd_hit[0]), 64'd1);
    check("a_n1_hitdata", rd_data[0], 64'hAA);
    check("a_n1_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("a_n1_stall", 64'(wb_stall), 64'd1);
    step();
    #1;
    check("a_n2_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    check("a_n2_wb_req", 64'(wb_req), 64'd1);
    check("a_n2_addr", proc2mem_addr, 64'h1228);
    check("a_n2_data", proc2mem_data, 64'hAA);
    step();
    mem2proc_response = 4'h1;
    #1;
    check("a_n3_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("a_n3_wb_req", 64'(wb_req), 64'd0);
    step();
    mem2proc_response = 4'h0;
    #1;
    check("a_n4_count", 64'(dut.count), 64'd0);
    check("a_n4_hit", 64'(rd_hit[0]), 64'd0);
    check("a_n4_stall", 64'(wb_stall), 64'd0);

    // Three dirty plus one clean eviction in one cycle
    do_reset();
    evicted_vic[0] = mk(1'b1, 5'd1, 56'h1, 64'h11);
    evicted_vic[1] = mk(1'b0, 5'd2, 56'h2, 64'h22);
    evicted_vic[2] = mk(1'b1, 5'd3, 56'h3, 64'h33);
    evicted_vic[3] = mk(1'b1, 5'd4, 56'h4, 64'h44);
    evicted_valid  = 4'b1111;
    step();
    evicted_valid = '0;
    lookup(0, 5'd2, 56'h2);
    lookup(1, 5'd4, 56'h4);
    #1;
    check("b_count", 64'(dut.count), 64'd3);
    check("b_stall", 64'(wb_stall), 64'd1);
    check("b_overflow", 64'(wb_overflow), 64'd0);
    check("b_clean_hit", 64'(rd_hit[0]), 64'd0);
    check("b_p3_hit", 64'(rd_hit[1]), 64'd1);
    check("b_p3_data", rd_data[1], 64'h44);
    rd_en     = '0;
    mem_grant = 1'b1;
    serve("b_first", 64'h108, 64'h11, 4'h1);
    serve("b_second", 64'h318, 64'h33, 4'h1);
    serve("b_third", 64'h420, 64'h44, 4'h1);
    no_store_window("b_no_clean_store", 8);
    check("b_drained", 64'(dut.count), 64'd0);

    // FIFO at three entries, three more dirty evictions
    do_reset();
    evicted_vic[0] = mk(1'b1, 5'd1, 56'h21, 64'h201);
    evicted_vic[1] = mk(1'b1, 5'd2, 56'h22, 64'h202);
    evicted_vic[2] = mk(1'b1, 5'd3, 56'h23, 64'h203);
    evicted_valid  = 4'b0111;
    step();
    evicted_vic[0] = mk(1'b1, 5'd10, 56'h30, 64'h300);
    evicted_vic[1] = mk(1'b1, 5'd11, 56'h31, 64'h301);
    evicted_vic[2] = mk(1'b1, 5'd12, 56'h32, 64'h302);
    evicted_valid  = 4'b0111;
    #1;
    check("c_pre_overflow", 64'(wb_overflow), 64'd0);
    step();
    evicted_valid = '0;
    lookup(0, 5'd10, 56'h30);
    lookup(1, 5'd11, 56'h31);
    #1;
    check("c_count", 64'(dut.count), 64'd4);
    check("c_overflow", 64'(wb_overflow), 64'd1);
    check("c_stall", 64'(wb_stall), 64'd1);
    check("c_p0_hit", 64'(rd_hit[0]), 64'd1);
    check("c_p0_data", rd_data[0], 64'h300);
    check("c_p1_dropped", 64'(rd_hit[1]), 64'd0);
    step();
    #1;
    check("c_overflow_once", 64'(wb_overflow), 64'd0);
    check("c_count_hold", 64'(dut.count), 64'd4);

    // Two failed responses then success: same line issued three times
    do_reset();
    evicted_vic[0] = mk(1'b1, 5'd7, 56'h77, 64'hDEADBEEF);
    evicted_valid  = 4'b0001;
    mem_grant      = 1'b1;
    step();
    evicted_valid = '0;
    serve("d_try1", 64'h7738, 64'hDEADBEEF, 4'h0);
    check("d_count1", 64'(dut.count), 64'd1);
    serve("d_try2", 64'h7738, 64'hDEADBEEF, 4'h0);
    check("d_count2", 64'(dut.count), 64'd1);
    serve("d_try3", 64'h7738, 64'hDEADBEEF, 4'h2);
    #1;
    check("d_single_pop", 64'(dut.count), 64'd0);
    no_store_window("d_no_extra_store", 6);

    // Same idx/tag twice: youngest wins; same-cycle eviction not searched
    do_reset();
    evicted_vic[0] = mk(1'b1, 5'd9, 56'h55, 64'h1);
    evicted_valid  = 4'b0001;
    lookup(0, 5'd9, 56'h55);
    #1;
    check("e_same_cycle_hit", 64'(rd_hit[0]), 64'd0);
    step();
    evicted_vic[0] = mk(1'b1, 5'd9, 56'h55, 64'h2);
    #1;
    check("e_first_data", rd_data[0], 64'h1);
    step();
    evicted_valid = '0;
    lookup(1, 5'd9, 56'h55);
    #1;
    check("e_hit0", 64'(rd_hit[0]), 64'd1);
    check("e_data0", rd_data[0], 64'h2);
    check("e_hit1", 64'(rd_hit[1]), 64'd1);
    check("e_data1", rd_data[1], 64'h2);
    rd_en = 2'b10;
    #1;
    check("e_disabled_hit", 64'(rd_hit[0]), 64'd0);
    check("e_disabled_data", rd_data[0], 64'd0);

    // Reset during WAIT abandons the store and both entries
    do_reset();
    evicted_vic[0] = mk(1'b1, 5'd6, 56'h60, 64'h600);
    evicted_vic[1] = mk(1'b1, 5'd7, 56'h61, 64'h610);
    evicted_valid  = 4'b0011;
    mem_grant      = 1'b1;
    step();
    evicted_valid = '0;
    lookup(0, 5'd6, 56'h60);
    wait_store("f_before_reset");
    step();
    reset = 1'b0;
    #1;
    check("f_rst_wb_req", 64'(wb_req), 64'd0);
    check("f_rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("f_rst_addr", proc2mem_addr, 64'd0);
    check("f_rst_data", proc2mem_data, 64'd0);
    check("f_rst_hit", 64'(rd_hit), 64'd0);
    check("f_rst_stall", 64'(wb_stall), 64'd0);
    check("f_rst_count", 64'(dut.count), 64'd0);
    step();
    step();
    reset = 1'b1;
    no_store_window("f_no_store_after_reset", 10);
    check("f_count_after", 64'(dut.count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vic_wb_buffer.md
VIC_WB_BUFFER -- requirements
Module: vic_wb_buffer

Interface
REQ-001 SHALL have parameter WR_PORTS, default 3, meaning the number of eviction ports from the victim cache.
REQ-002 SHALL have parameter RD_PORTS, default 2, meaning the number of load-forwarding lookup ports.
REQ-003 SHALL have parameter WB_SIZE, default 4, meaning the number of buffer entries (power of two).
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-006 evicted_vic  in  WR_PORTS x VIC_CACHE_T  lines leaving the victim cache.
REQ-007 evicted_valid  in  WR_PORTS  per-port valid for evicted_vic.
REQ-008 rd_en  in  RD_PORTS  lookup enable.
REQ-009 rd_idx  in  RD_PORTS x NUM_SET_BITS  lookup set index.
REQ-010 rd_tag  in  RD_PORTS x NUM_TAG_BITS  lookup tag.
REQ-011 rd_hit  out  RD_PORTS  lookup matched a pending writeback.
REQ-012 rd_data  out  RD_PORTS x 64  data of the matching entry; 0 when no hit.
REQ-013 mem_grant  in  1  memory arbiter grants the bus to this block this cycle.
REQ-014 wb_req  out  1  block requests the bus.
REQ-015 proc2mem_command  out  2  BUS_STORE when issuing, else BUS_NONE.
REQ-016 proc2mem_addr  out  64  {tag, idx, 3'b0} of the head entry.
REQ-017 proc2mem_data  out  64  data of the head entry.
REQ-018 mem2proc_response  in  4  nonzero = store accepted this cycle.
REQ-019 wb_stall  out  1  free entries < WR_PORTS; upstream holds off further evictions.
REQ-020 wb_overflow  out  1  one-cycle pulse when an eviction was dropped.

Function
REQ-021 SHALL enqueue only ports with evicted_valid=1 and line.valid=1 and line.dirty=1; clean lines are discarded silently.
REQ-022 SHALL enqueue accepted ports in ascending port order, lowest port into the oldest free slot, in one cycle.
REQ-023 SHALL compute free slots from the registered count only; a dequeue in the same cycle gives no credit.
REQ-024 SHALL drop qualifying ports beyond the free slots (highest ports first) and pulse wb_overflow the next cycle.
REQ-025 SHALL use a circular FIFO with head/tail pointers of log2(WB_SIZE)+1 bits, so wrap-around distinguishes full from empty.
REQ-026 SHALL implement the FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-027 IDLE: if the FIFO is non-empty, go to REQ next cycle.
REQ-028 REQ: assert wb_req; when mem_grant=1, drive BUS_STORE with the head address and data, then go to WAIT.
REQ-029 WAIT: drive BUS_NONE; on the first cycle mem2proc_response!=0, pop the head and go to IDLE; if the response is 0 on the cycle after the store was driven, return to REQ (retry).
REQ-030 SHALL hold the head entry unchanged until it is popped, including during retry.
REQ-031 SHALL keep proc2mem_command=BUS_NONE whenever not in REQ with grant.
REQ-032 Lookup SHALL be combinational against registered valid entries, including the in-flight head; the youngest match wins; same-cycle incoming evictions are not searched.
REQ-033 rd_hit SHALL be 0 when rd_en=0.
REQ-034 SHALL allow simultaneous enqueue and pop; count_next = count + enq - pop.
REQ-035 Latency: an entry enqueued at cycle N SHALL be visible to lookup and the FSM at N+1; earliest BUS_STORE is at N+2.

Reset
REQ-036 While reset=0, all entries SHALL be invalid, head=tail=count=0, FSM=IDLE, wb_req=0, proc2mem_command=BUS_NONE, addr/data=0, rd_hit=0, wb_stall=0, wb_overflow=0.
REQ-037 A reset mid-store (in REQ or WAIT) SHALL abandon the store; the pending entry is lost and no retry follows.

Structure
REQ-038 WB_SIZE, NUM_WB_BITS, the FSM state enum WB_STATE_T, and the BUS_* command encodings SHALL live in sys_defs; the block reuses VIC_CACHE_T and EMPTY_VIC_CACHE.
REQ-039 The lookup SHALL instantiate the existing CAM module (LENGTH=WB_SIZE, NUM_TAGS=RD_PORTS); no other sub-module.

Verification
REQ-040 One dirty eviction (idx=5, tag=0x12, data=0xAA), mem_grant=1, response=1 one cycle after the store -> BUS_STORE at N+2 with addr={0x12,5,000}, FIFO empty at N+4.
REQ-041 Three dirty evictions plus one clean eviction in one cycle -> count=3, wb_stall=1; the clean line never appears on the bus.
REQ-042 FIFO at 3 entries, 3 new dirty evictions -> port 0 accepted, ports 1-2 dropped, wb_overflow pulses once.
REQ-043 mem2proc_response=0 twice, then 2 -> the same addr/data is reissued three times; a single pop.
REQ-044 Two entries with the same idx/tag (data 0x1 then 0x2), rd_en=1 for that idx/tag -> rd_hit=1, rd_data=0x2; rd_en=0 -> rd_hit=0.
REQ-045 reset=0 asserted during WAIT with 2 entries -> all outputs at reset values immediately; after release, no BUS_STORE is issued.
